// File: rtl/enemy_formation_ctrl.sv
// Enemy formation sequencer: march timing, edge turns and drops, alive bookkeeping, win/lose.
// Publishes the formation origin; each sprite adds (col*CELL_W, row*ROW_H) to it.
module enemy_formation_ctrl #(
  parameter int COLS        = 7,
  parameter int ROWS        = 3,
  parameter int CELL_W      = 73,
  parameter int ROW_H       = 50,
  parameter int ENEMY_W     = 49,
  parameter int ENEMY_H     = 43,
  parameter int SCREEN_W    = 640,
  parameter int LOSE_Y      = 355,
  parameter int STEP_X      = 1,
  parameter int STEP_Y      = 8,
  parameter int MIN_PERIOD  = 1,
  parameter int SPEED_SHIFT = 2
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   frame_clk,
  input  logic                   Start,
  input  logic                   kill_valid,
  input  logic [4:0]             kill_index,
  output logic signed [10:0]     formation_x,
  output logic [9:0]             formation_y,
  output logic                   dir_x,
  output logic                   dir_y,
  output logic                   step,
  output logic [ROWS*COLS-1:0]   alive_mask,
  output logic [4:0]             alive_count,
  output logic                   game_lost,
  output logic                   game_won
);

  localparam int N  = ROWS * COLS;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic signed [11:0] STEP_X12  = 12'(STEP_X);
  localparam logic signed [11:0] RIGHT_LIM = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] LOSE_Y12  = 12'(LOSE_Y);
  localparam logic signed [11:0] W_M1      = 12'(ENEMY_W - 1);
  localparam logic signed [11:0] H_M1      = 12'(ENEMY_H - 1);
  localparam logic [N-1:0]       ALL_ALIVE = {N{1'b1}};
  localparam logic [N-1:0]       ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    MARCH_RIGHT = 3'd1,
    MARCH_LEFT  = 3'd2,
    LOST        = 3'd3,
    WON         = 3'd4
  } state_t;

  function automatic logic [4:0] popcount(input logic [N-1:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < N; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

  state_t state_r, state_next;
  logic frame_prev_r;
  logic [7:0] frame_cnt_r, cnt_next, period_s;
  logic tick_s, step_due_s, none_alive_s, kill_ok_s;
  logic [COLS-1:0] col_alive_s;
  logic [ROWS-1:0] row_alive_s;
  logic [CW-1:0] lcol_s, rcol_s;
  logic [RW-1:0] brow_s;
  logic signed [11:0] x_ext_s, loff_s, roff_s, boff_s;
  logic signed [11:0] left_edge_s, right_edge_s, bottom_drop_s;
  logic [9:0] y_drop_s;
  logic hit_right_s, hit_left_s, drop_s, lose_s;
  logic signed [10:0] x_next;
  logic [9:0] y_next;
  logic dx_next, dy_next, step_next, lost_next, won_next;
  logic [N-1:0] mask_next;

  // Occupied column span and lowest occupied row from the registered mask
  always_comb begin
    col_alive_s = '0;
    row_alive_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        col_alive_s[c] = col_alive_s[c] | alive_mask[r*COLS + c];
        row_alive_s[r] = row_alive_s[r] | alive_mask[r*COLS + c];
      end
    end
    lcol_s = '0;
    rcol_s = '0;
    brow_s = '0;
    for (int c = COLS - 1; c >= 0; c--) lcol_s = col_alive_s[c] ? CW'(c) : lcol_s;
    for (int c = 0; c < COLS; c++)      rcol_s = col_alive_s[c] ? CW'(c) : rcol_s;
    for (int r = 0; r < ROWS; r++)      brow_s = row_alive_s[r] ? RW'(r) : brow_s;
  end

  assign x_ext_s       = {formation_x[10], formation_x};
  assign loff_s        = 12'(32'(lcol_s) * CELL_W);
  assign roff_s        = 12'(32'(rcol_s) * CELL_W);
  assign boff_s        = 12'(32'(brow_s) * ROW_H);
  assign left_edge_s   = x_ext_s + loff_s;
  assign right_edge_s  = x_ext_s + roff_s + W_M1;
  assign y_drop_s      = formation_y + 10'(STEP_Y);
  assign bottom_drop_s = {2'b00, y_drop_s} + boff_s + H_M1;
  assign hit_right_s   = (right_edge_s + STEP_X12) > RIGHT_LIM;
  assign hit_left_s    = (left_edge_s - STEP_X12) < 12'sd0;
  assign drop_s        = (state_r == MARCH_RIGHT) ? hit_right_s : hit_left_s;
  assign lose_s        = bottom_drop_s >= LOSE_Y12;

  assign tick_s       = frame_clk & ~frame_prev_r;
  assign period_s     = 8'(MIN_PERIOD) + 8'({3'b000, alive_count} >> SPEED_SHIFT);
  assign step_due_s   = tick_s && ((frame_cnt_r + 8'd1) >= period_s);
  assign none_alive_s = (alive_mask == '0);
  assign kill_ok_s    = kill_valid && (kill_index < 5'(N));

  // State register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next state: an empty formation wins before any drop can lose
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE, LOST, WON: begin
        state_next = Start ? MARCH_RIGHT : state_r;
      end
      MARCH_RIGHT, MARCH_LEFT: begin
        if (none_alive_s) begin
          state_next = WON;
        end else if (step_due_s && drop_s) begin
          state_next = lose_s ? LOST :
                       ((state_r == MARCH_RIGHT) ? MARCH_LEFT : MARCH_RIGHT);
        end else begin
          state_next = state_r;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Next values of the published registers
  always_comb begin
    x_next    = formation_x;
    y_next    = formation_y;
    dx_next   = dir_x;
    dy_next   = 1'b0;
    step_next = 1'b0;
    mask_next = alive_mask;
    cnt_next  = frame_cnt_r;
    lost_next = game_lost;
    won_next  = game_won;
    case (state_r)
      IDLE, LOST, WON: begin
        if (Start) begin
          x_next    = 11'sd0;
          y_next    = 10'd0;
          dx_next   = 1'b1;
          mask_next = ALL_ALIVE;
          cnt_next  = 8'd0;
          lost_next = 1'b0;
          won_next  = 1'b0;
        end else begin
          mask_next = alive_mask;
        end
      end
      MARCH_RIGHT, MARCH_LEFT: begin
        if (none_alive_s) begin
          won_next = 1'b1;
        end else begin
          if (tick_s) begin
            cnt_next = step_due_s ? 8'd0 : (frame_cnt_r + 8'd1);
          end else begin
            cnt_next = frame_cnt_r;
          end
          // Movement uses the pre-kill mask; a same-cycle kill lands on the same edge
          if (step_due_s) begin
            step_next = 1'b1;
            if (drop_s) begin
              y_next    = y_drop_s;
              dy_next   = 1'b1;
              dx_next   = (state_r == MARCH_LEFT);
              lost_next = lose_s;
            end else if (state_r == MARCH_RIGHT) begin
              x_next = formation_x + 11'(STEP_X);
            end else begin
              x_next = formation_x - 11'(STEP_X);
            end
          end else begin
            step_next = 1'b0;
          end
          mask_next = kill_ok_s ? (alive_mask & ~(ONE_HOT0 << kill_index)) : alive_mask;
        end
      end
      default: begin
        mask_next = alive_mask;
      end
    endcase
  end

  // Published registers, frame-edge register and frame counter
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_prev_r <= 1'b0;
      frame_cnt_r  <= 8'd0;
      formation_x  <= 11'sd0;
      formation_y  <= 10'd0;
      dir_x        <= 1'b1;
      dir_y        <= 1'b0;
      step         <= 1'b0;
      alive_mask   <= ALL_ALIVE;
      alive_count  <= 5'(N);
      game_lost    <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      frame_prev_r <= frame_clk;
      frame_cnt_r  <= cnt_next;
      formation_x  <= x_next;
      formation_y  <= y_next;
      dir_x        <= dx_next;
      dir_y        <= dy_next;
      step         <= step_next;
      alive_mask   <= mask_next;
      alive_count  <= popcount(mask_next);
      game_lost    <= lost_next;
      game_won     <= won_next;
    end
  end

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Scoreboard bench for enemy_formation_ctrl: a behavioural model queues each expected step,
// and every DUT step pulse pops and compares position/direction.
module tb_enemy_formation_ctrl;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  logic frame_clk = 1'b0;
  logic Start = 1'b0;
  logic kill_valid = 1'b0;
  logic [4:0] kill_index = 5'd0;
  logic signed [10:0] formation_x;
  logic [9:0] formation_y;
  logic dir_x, dir_y, step;
  logic [20:0] alive_mask;
  logic [4:0] alive_count;
  logic game_lost, game_won;

  int n_checks = 0;
  int n_pass = 0;
  int dut_steps = 0;
  int dut_drops = 0;
  logic [31:0] sb_q[$];
  logic fph = 1'b0;

  // model state: 0 idle, 1 right, 2 left, 3 lost, 4 won
  int m_state, m_x, m_y, m_cnt;
  logic m_dx, m_prev, m_lost, m_won;
  logic [20:0] m_mask;

  always #5 Clk = ~Clk;

  enemy_formation_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .Start(Start),
    .kill_valid(kill_valid), .kill_index(kill_index),
    .formation_x(formation_x), .formation_y(formation_y),
    .dir_x(dir_x), .dir_y(dir_y), .step(step),
    .alive_mask(alive_mask), .alive_count(alive_count),
    .game_lost(game_lost), .game_won(game_won)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 0; m_y = 0; m_cnt = 0;
    m_dx = 1'b1; m_prev = 1'b0; m_lost = 1'b0; m_won = 1'b0;
    m_mask = '1;
  endtask

  task automatic model_move();
    int lc, rc, br, le, re, bot;
    bit drop;
    lc = 7; rc = -1; br = -1;
    for (int i = 0; i < 21; i++) begin
      if (m_mask[i]) begin
        if (i % 7 < lc) lc = i % 7;
        if (i % 7 > rc) rc = i % 7;
        if (i / 7 > br) br = i / 7;
      end
    end
    le = m_x + lc * 73;
    re = m_x + rc * 73 + 48;
    drop = (m_state == 1) ? (re + 1 > 639) : (le - 1 < 0);
    if (drop) begin
      m_y = m_y + 8;
      m_dx = (m_state == 2);
      m_state = (m_state == 1) ? 2 : 1;
      bot = m_y + br * 50 + 42;
      if (bot >= 355) begin m_state = 3; m_lost = 1'b1; end
    end else begin
      m_x = m_x + ((m_state == 1) ? 1 : -1);
    end
    sb_q.push_back({9'd0, 11'(m_x), 10'(m_y), m_dx, drop});
  endtask

  task automatic model_cycle(input logic f, input logic kv, input logic [4:0] ki, input logic st);
    bit tk;
    int per;
    tk = f && !m_prev;
    m_prev = f;
    if (m_state == 0 || m_state >= 3) begin
      if (st) begin
        m_state = 1; m_x = 0; m_y = 0; m_mask = '1; m_cnt = 0;
        m_dx = 1'b1; m_lost = 1'b0; m_won = 1'b0;
      end
    end else if (m_mask == 21'd0) begin
      m_state = 4; m_won = 1'b1;
    end else begin
      if (tk) begin
        per = 1 + ($countones(m_mask) >> 2);
        if (m_cnt + 1 >= per) begin m_cnt = 0; model_move(); end
        else m_cnt = m_cnt + 1;
      end
      if (kv && ki < 5'd21) m_mask[ki] = 1'b0;
    end
  endtask

  // one clock: drive inputs, advance model, then score the DUT response
  task automatic cyc(input logic f, input logic kv, input logic [4:0] ki, input logic st);
    logic [31:0] e;
    frame_clk = f; kill_valid = kv; kill_index = ki; Start = st;
    model_cycle(f, kv, ki, st);
    @(posedge Clk); #1;
    if (dir_y) dut_drops++;
    if (step) begin
      dut_steps++;
      if (sb_q.size() == 0) check_val("step_unexpected", 32'(step), 32'd0);
      else begin
        e = sb_q.pop_front();
        check_val("step_pos", {9'd0, formation_x, formation_y, dir_x, dir_y}, e);
      end
    end else if (sb_q.size() != 0) begin
      check_val("step_missing", 32'(step), 32'd1);
      sb_q.delete();
    end
  endtask

  task automatic tcyc(input logic kv, input logic [4:0] ki, input logic st);
    fph = ~fph;
    cyc(fph, kv, ki, st);
  endtask

  task automatic wait_drops(input int target, input int limit);
    int g;
    g = 0;
    while (dut_drops < target && g < limit) begin tcyc(1'b0, 5'd0, 1'b0); g++; end
    check_val("drop_wait", 32'(dut_drops), 32'(target));
  endtask

  task automatic check_state(input string tag);
    check_val({tag, "_x"}, 32'(formation_x), 32'(m_x));
    check_val({tag, "_y"}, 32'(formation_y), 32'(m_y));
    check_val({tag, "_dx"}, 32'(dir_x), 32'(m_dx));
    check_val({tag, "_mask"}, 32'(alive_mask), 32'(m_mask));
    check_val({tag, "_cnt"}, 32'(alive_count), 32'($countones(m_mask)));
    check_val({tag, "_lost"}, 32'(game_lost), 32'(m_lost));
    check_val({tag, "_won"}, 32'(game_won), 32'(m_won));
  endtask

  initial begin
    logic [20:0] expm;
    int g, s;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      frame_clk = ~frame_clk;
      @(posedge Clk); #1;
      check_val("rst_step", 32'(step), 32'd0);
    end
    check_val("rst_x", 32'(formation_x), 32'd0);
    check_val("rst_mask", 32'(alive_mask), 32'h1FFFFF);
    check_val("rst_count", 32'(alive_count), 32'd21);
    check_state("rst");
    Reset_n = 1'b1;
    fph = frame_clk;

    repeat (10) tcyc(1'b0, 5'd0, 1'b0);
    check_state("idle");

    // start, then hold Start high through 12 frame ticks
    tcyc(1'b0, 5'd0, 1'b1);
    repeat (24) tcyc(1'b0, 5'd0, 1'b1);
    check_val("t12_steps", 32'(dut_steps), 32'd2);
    check_val("t12_x", 32'(formation_x), 32'd2);
    check_val("t12_dx", 32'(dir_x), 32'd1);
    check_state("t12");

    wait_drops(1, 6000);
    check_val("turn1_x", 32'(formation_x), 32'd153);
    check_val("turn1_y", 32'(formation_y), 32'd8);
    check_val("turn1_dy", 32'(dir_y), 32'd1);
    check_val("turn1_dx", 32'(dir_x), 32'd0);
    s = dut_steps + 1;
    g = 0;
    while (dut_steps < s && g < 100) begin tcyc(1'b0, 5'd0, 1'b0); g++; end
    check_val("left1_x", 32'(formation_x), 32'd152);

    tcyc(1'b1, 5'd6, 1'b0);
    tcyc(1'b1, 5'd13, 1'b0);
    tcyc(1'b1, 5'd20, 1'b0);
    tcyc(1'b1, 5'd6, 1'b0);
    tcyc(1'b1, 5'd25, 1'b0);
    tcyc(1'b0, 5'd0, 1'b0);
    expm = 21'h1FFFFF;
    expm[6] = 1'b0; expm[13] = 1'b0; expm[20] = 1'b0;
    check_val("kill_count", 32'(alive_count), 32'd18);
    check_val("kill_mask", 32'(alive_mask), 32'(expm));
    check_state("kill");

    wait_drops(2, 8000);
    check_val("turn2_x", 32'(formation_x), 32'd0);
    check_val("turn2_y", 32'(formation_y), 32'd16);
    wait_drops(3, 8000);
    check_val("turn3_x", 32'(formation_x), 32'd226);
    check_val("turn3_y", 32'(formation_y), 32'd24);

    // keep only enemies 14 and 19 so the period bottoms out at one frame
    for (int i = 0; i < 21; i++) begin
      if (i != 14 && i != 19) tcyc(1'b1, 5'(i), 1'b0);
    end
    check_val("thin_count", 32'(alive_count), 32'd2);
    g = 0;
    while (!game_lost && g < 40000) begin tcyc(1'b0, 5'd0, 1'b0); g++; end
    check_val("lost_wait", 32'(game_lost), 32'd1);
    check_val("lost_y", 32'(formation_y), 32'd216);
    check_state("lost");
    s = dut_steps;
    repeat (20) tcyc(1'b1, 5'd14, 1'b0);
    check_val("lost_halt", 32'(dut_steps), 32'(s));
    check_val("lost_nokill", 32'(alive_mask[14]), 32'd1);

    tcyc(1'b0, 5'd0, 1'b1);
    check_val("restart_x", 32'(formation_x), 32'd0);
    check_val("restart_y", 32'(formation_y), 32'd0);
    check_val("restart_lost", 32'(game_lost), 32'd0);
    check_val("restart_mask", 32'(alive_mask), 32'h1FFFFF);
    check_state("restart");

    for (int i = 0; i < 20; i++) tcyc(1'b1, 5'(i), 1'b0);
    cyc(1'b0, 1'b0, 5'd0, 1'b0);
    cyc(1'b1, 1'b1, 5'd20, 1'b0);
    fph = 1'b1;
    check_val("final_step", 32'(step), 32'd1);
    check_val("final_mask", 32'(alive_mask), 32'd0);
    check_val("final_won_early", 32'(game_won), 32'd0);
    tcyc(1'b0, 5'd0, 1'b0);
    check_val("won", 32'(game_won), 32'd1);
    check_val("won_count", 32'(alive_count), 32'd0);
    s = dut_steps;
    repeat (10) tcyc(1'b0, 5'd0, 1'b0);
    check_val("won_halt", 32'(dut_steps), 32'(s));
    check_state("won");

    tcyc(1'b0, 5'd0, 1'b1);
    check_val("rewin_won", 32'(game_won), 32'd0);
    repeat (30) tcyc(1'b0, 5'd0, 1'b0);
    check_state("premid");
    #2;
    Reset_n = 1'b0;
    #1;
    check_val("arst_x", 32'(formation_x), 32'd0);
    check_val("arst_y", 32'(formation_y), 32'd0);
    check_val("arst_mask", 32'(alive_mask), 32'h1FFFFF);
    check_val("arst_count", 32'(alive_count), 32'd21);
    check_val("arst_dx", 32'(dir_x), 32'd1);
    check_val("arst_dy", 32'(dir_y), 32'd0);
    check_val("arst_step", 32'(step), 32'd0);
    check_val("arst_flags", {30'd0, game_lost, game_won}, 32'd0);
    model_reset();
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    fph = frame_clk;
    repeat (8) tcyc(1'b0, 5'd0, 1'b0);
    check_state("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/enemy_formation_ctrl.md
Name: enemy_formation_ctrl

Overview:
- Sequences the 3x7 enemy formation: march timing, left/right/down direction, alive bookkeeping, win/lose detection.
- Publishes one formation origin (x,y) plus per-enemy alive mask; enemy sprite instances derive position as origin + (col*CELL_W, row*ROW_H).
- Runs on Clk; frame_clk is sampled as a synchronous input and edge-detected (no logic clocked by frame_clk).

Parameters:
- COLS, 7, enemies per row
- ROWS, 3, enemy rows (index = row*COLS + col)
- CELL_W, 73, horizontal pitch in pixels
- ROW_H, 50, vertical pitch in pixels
- ENEMY_W, 49, sprite width
- ENEMY_H, 43, sprite height
- SCREEN_W, 640, visible width
- LOSE_Y, 355, bottom-edge pixel row that loses the game
- STEP_X, 1, pixels per horizontal step
- STEP_Y, 8, pixels per drop
- MIN_PERIOD, 1, minimum frames per step
- SPEED_SHIFT, 2, period = MIN_PERIOD + (alive_count >> SPEED_SHIFT)

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  vertical-sync rate signal; rising edge = one frame tick
- Start  in  1  level; starts/restarts a wave
- kill_valid  in  1  one-cycle kill request
- kill_index  in  5  enemy index 0..20
- formation_x  out  11  signed origin x
- formation_y  out  10  origin y
- dir_x  out  1  1 = moving right
- dir_y  out  1  1 for the cycle of a drop step
- step  out  1  one-cycle pulse on every movement
- alive_mask  out  21  bit i = enemy i alive
- alive_count  out  5  popcount of alive_mask
- game_lost  out  1  sticky until Start/reset
- game_won  out  1  sticky until Start/reset

Behaviour:
- Reset (async, Reset_n=0): state IDLE, formation_x=0, formation_y=0, dir_x=1, dir_y=0, step=0, alive_mask=all 1, alive_count=21, game_lost=0, game_won=0, frame counter=0, frame_clk edge register=0.
- Frame tick: frame_clk rising edge detected with one register; tick is a one-Clk pulse one cycle after the edge.
- States: IDLE, MARCH_RIGHT, MARCH_LEFT, LOST, WON.
- IDLE: Start=1 -> load x=0, y=0, alive_mask all 1, clear frame counter, dir_x=1 -> MARCH_RIGHT.
- Step timing: in MARCH_*, each tick increments frame counter; when counter+1 >= period (period computed from current alive_count), counter clears and one step executes that cycle.
- Extents use the registered alive_mask: lcol/rcol = lowest/highest column with any alive enemy; brow = highest row with any alive enemy. left_edge = x + lcol*CELL_W; right_edge = x + rcol*CELL_W + ENEMY_W - 1; bottom_edge = y + brow*ROW_H + ENEMY_H - 1. All extent arithmetic is 12-bit signed.
- MARCH_RIGHT step: if right_edge + STEP_X > SCREEN_W-1, drop: y += STEP_Y, dir_y=1, dir_x=0 -> MARCH_LEFT. Otherwise x += STEP_X.
- MARCH_LEFT step: if left_edge - STEP_X < 0, drop: y += STEP_Y, dir_x=1 -> MARCH_RIGHT. Otherwise x -= STEP_X.
- step pulses high in the same cycle the registers update; dir_y is high only in a drop cycle.
- Lose check: after any drop, if new bottom_edge >= LOSE_Y -> LOST with game_lost=1. Movement halts.
- Kill: with kill_valid=1 and kill_index<21, clear the bit the next cycle. Indices >= 21 and kills of dead enemies are ignored. Kills are ignored in IDLE, LOST, and WON.
- Kill and step in the same cycle: the step uses the pre-kill mask; the kill lands in the same clock edge.
- alive_mask==0 in MARCH_* -> WON next cycle, game_won=1. WON has priority over a same-cycle drop that would lose.
- LOST/WON: Start=1 -> same reload as IDLE start; flags cleared.
- Start held high while marching has no effect.
- Reset mid-march returns immediately to the reset values.

Test Plan:
- Reset with frame_clk toggling -> x=0, y=0, mask=0x1FFFFF, count=21, step never pulses while IDLE.
- Start, then 12 frame ticks -> period 6: step pulses on ticks 6 and 12, x=2, dir_x=1.
- Continue to x=153 (right_edge=639); next step -> y=8, x=153, dir_y pulse, MARCH_LEFT; following step x=152.
- Kill indices 6, 13, 20 (column 6); kill 6 again; kill 25 -> count=18, period 5, duplicates/invalid ignored; right turn now at x=226 (right_edge=412+...=639).
- Force drops until y=216 (bottom_edge=358>=355) -> LOST, game_lost=1, no further steps; Start -> MARCH_RIGHT, x=0, y=0, flags clear.
- Kill all 21 with the final kill coincident with a step -> step executes, then WON, game_won=1. Assert Reset_n=0 mid-march -> all outputs at reset values asynchronously.
